// File: rtl/rhd_cmd_sequencer_if.sv
// Command word stream between the frame sequencer and the RHD SPI word engine.
interface rhd_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_data;
  logic        cmd_last;

  modport master (output cmd_valid, output cmd_data, output cmd_last, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_data, input cmd_last, output cmd_ready);
endinterface

// File: rtl/rhd_cmd_sequencer.sv
// Frame-level command scheduler for the RHD SPI engine: one frame of CONVERT
// commands plus auxiliary commands from a circular list per sample period.
// Word indices are 6 bits wide, so NUM_CH + NUM_AUX must not exceed 64.
module rhd_cmd_sequencer #(
  parameter int SAMPLE_DIV = 1960,
  parameter int NUM_CH     = 32,
  parameter int NUM_AUX    = 3,
  parameter int AUX_DEPTH  = 128,
  parameter int PKT_W      = 16,
  localparam int AUX_AW    = $clog2(AUX_DEPTH)
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 run_en,
  input  logic                 dsp_settle,
  input  logic [PKT_W-1:0]     pkt_len,
  input  logic [AUX_AW:0]      aux_len,
  input  logic                 aux_wr_en,
  input  logic [AUX_AW-1:0]    aux_wr_addr,
  input  logic [15:0]          aux_wr_data,
  rhd_cmd_sequencer_if.master  cmd,
  output logic                 frame_start,
  output logic                 packet_done,
  output logic                 running,
  output logic                 overrun,
  output logic [PKT_W-1:0]     frame_cnt
);

  localparam int                 TIMER_W   = $clog2(SAMPLE_DIV);
  localparam logic [TIMER_W-1:0] TICK_CNT  = TIMER_W'(SAMPLE_DIV - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
  localparam logic [5:0]         CH_END    = 6'(NUM_CH);
  localparam logic [5:0]         LAST_IDX  = 6'(NUM_CH + NUM_AUX - 1);
  localparam logic [AUX_AW-1:0]  AUX_ONE   = AUX_AW'(1);
  localparam logic [AUX_AW:0]    ALEN_ONE  = (AUX_AW+1)'(1);
  localparam logic [PKT_W-1:0]   PKT_ONE   = PKT_W'(1);

  typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;

  state_t              state, state_nxt;
  logic [TIMER_W-1:0]  timer;
  logic [5:0]          word_idx;
  logic [5:0]          next_idx;
  logic [15:0]         next_word;
  logic [AUX_AW-1:0]   aux_idx, aux_idx_nxt;
  logic [15:0]         aux_rd;
  logic [15:0]         aux_mem [AUX_DEPTH];
  logic [AUX_AW:0]     eff_aux_len;
  logic [PKT_W-1:0]    eff_pkt_len;
  logic                tick, accept, last_accept, aux_wrap, pkt_wrap;
  logic                start, launch, load;

  assign eff_aux_len = (aux_len == '0) ? ALEN_ONE : aux_len;
  assign eff_pkt_len = (pkt_len == '0) ? PKT_ONE : pkt_len;
  assign tick        = (state != IDLE) && (timer == TICK_CNT);
  assign accept      = cmd.cmd_valid & cmd.cmd_ready;
  assign last_accept = accept & cmd.cmd_last;
  assign aux_wrap    = ({1'b0, aux_idx} >= (eff_aux_len - ALEN_ONE));
  assign pkt_wrap    = (frame_cnt >= (eff_pkt_len - PKT_ONE));
  assign running     = (state != IDLE);
  assign frame_start = accept && (word_idx == 6'd0);
  assign packet_done = last_accept && pkt_wrap;

  // State register; reset aborts any frame in flight.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state plus the start (leave IDLE) and launch (begin frame) strobes.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    launch    = 1'b0;
    case (state)
      IDLE: if (run_en) begin
        state_nxt = WAIT;
        start     = 1'b1;
      end
      WAIT: begin
        if (!run_en) state_nxt = IDLE;
        else if (tick) begin
          state_nxt = ISSUE;
          launch    = 1'b1;
        end
      end
      ISSUE: if (last_accept) state_nxt = run_en ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Select the next word to present; the aux read uses the post-advance index and bypasses a same-cycle write.
  always_comb begin
    aux_idx_nxt = aux_idx;
    if (accept && (word_idx >= CH_END)) aux_idx_nxt = aux_wrap ? '0 : aux_idx + AUX_ONE;
    aux_rd = aux_mem[aux_idx_nxt];
    if (aux_wr_en && (aux_wr_addr == aux_idx_nxt)) aux_rd = aux_wr_data;
    next_idx  = launch ? 6'd0 : word_idx + 6'd1;
    next_word = (next_idx < CH_END) ? {2'b00, next_idx, 7'b0000000, dsp_settle} : aux_rd;
    load      = launch | (accept & ~cmd.cmd_last);
  end

  // Sample timer, registered command output, aux pointer, overrun flag and packet counter.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      timer         <= '0;
      word_idx      <= '0;
      cmd.cmd_valid <= 1'b0;
      cmd.cmd_data  <= '0;
      cmd.cmd_last  <= 1'b0;
      aux_idx       <= '0;
      overrun       <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      if (state == IDLE || tick) timer <= '0;
      else                       timer <= timer + TIMER_ONE;

      if (load) begin
        cmd.cmd_valid <= 1'b1;
        cmd.cmd_data  <= next_word;
        cmd.cmd_last  <= (next_idx == LAST_IDX);
        word_idx      <= next_idx;
      end else if (last_accept) begin
        cmd.cmd_valid <= 1'b0;
        cmd.cmd_last  <= 1'b0;
      end

      if (start) aux_idx <= '0;
      else       aux_idx <= aux_idx_nxt;

      if (start)                      overrun <= 1'b0;
      else if (tick && state == ISSUE) overrun <= 1'b1;

      if (start)            frame_cnt <= '0;
      else if (last_accept) frame_cnt <= pkt_wrap ? '0 : frame_cnt + PKT_ONE;
    end
  end

  // Aux command list: synchronous write, contents not reset.
  always_ff @(posedge aclk) begin
    if (aux_wr_en) aux_mem[aux_wr_addr] <= aux_wr_data;
  end

endmodule

// File: tb/tb_rhd_cmd_sequencer.sv
// Directed testbench for rhd_cmd_sequencer with a word-level reference model.
module tb_rhd_cmd_sequencer;

  localparam int SAMPLE_DIV = 100;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        run_en;
  logic        dsp_settle;
  logic [15:0] pkt_len;
  logic [7:0]  aux_len;
  logic        aux_wr_en;
  logic [6:0]  aux_wr_addr;
  logic [15:0] aux_wr_data;
  logic        frame_start, packet_done, running, overrun;
  logic [15:0] frame_cnt;

  rhd_cmd_sequencer_if cmd_if();

  rhd_cmd_sequencer #(
    .SAMPLE_DIV(SAMPLE_DIV), .NUM_CH(32), .NUM_AUX(3), .AUX_DEPTH(128), .PKT_W(16)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .run_en(run_en), .dsp_settle(dsp_settle),
    .pkt_len(pkt_len), .aux_len(aux_len), .aux_wr_en(aux_wr_en),
    .aux_wr_addr(aux_wr_addr), .aux_wr_data(aux_wr_data), .cmd(cmd_if),
    .frame_start(frame_start), .packet_done(packet_done), .running(running),
    .overrun(overrun), .frame_cnt(frame_cnt)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int ready_mode = 0;
  int pcnt = 0;
  int m_pos = 0, m_aux = 0, m_fc = 0;
  int frames_done = 0, frames_since_start = 0, words_acc = 0, stall_cnt = 0;
  logic prev_stall = 1'b0, prev_run = 1'b0, prev_last = 1'b0;
  logic [15:0] prev_data = '0;
  logic [15:0] aux_tb [8];
  logic [15:0] frame_log [$];
  logic [15:0] aux_log [$];
  int pd_log [$];

  // Count one comparison and report it when it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic run, input int mode, input logic settle);
    @(posedge aclk); #1;
    run_en     = run;
    ready_mode = mode;
    dsp_settle = settle;
  endtask

  task automatic writeAux(input int addr, input logic [15:0] data);
    @(posedge aclk); #1;
    aux_wr_en   = 1'b1;
    aux_wr_addr = 7'(addr);
    aux_wr_data = data;
    @(posedge aclk); #1;
    aux_wr_en   = 1'b0;
  endtask

  task automatic waitFrames(input int target, input int budget);
    int k = 0;
    while (frames_done < target && k < budget) begin @(negedge aclk); k++; end
    if (frames_done < target) checkOutput("frames_timeout", frames_done, target);
  endtask

  task automatic waitRunning(input logic level, input int budget);
    int k = 0;
    @(negedge aclk);
    while (running !== level && k < budget) begin @(negedge aclk); k++; end
    if (running !== level) checkOutput("running_timeout", running, level);
  endtask

  task automatic waitValid(input int budget);
    int k = 0;
    @(negedge aclk);
    while (cmd_if.cmd_valid !== 1'b1 && k < budget) begin @(negedge aclk); k++; end
    if (cmd_if.cmd_valid !== 1'b1) checkOutput("valid_timeout", cmd_if.cmd_valid, 1);
  endtask

  task automatic waitPos(input int p, input int budget);
    int k = 0;
    while (m_pos != p && k < budget) begin @(negedge aclk); k++; end
    if (m_pos != p) checkOutput("pos_timeout", m_pos, p);
  endtask

  function automatic logic [15:0] conv(input int idx, input logic s);
    return {2'b00, 6'(idx), 7'b0000000, s};
  endfunction

  always @(posedge aclk) cyc++;

  // Ready pattern generator: 0 = always ready, 1 = 1,0,0,1 repeating, other = never ready.
  initial begin
    cmd_if.cmd_ready = 1'b0;
    forever begin
      @(posedge aclk); #2;
      case (ready_mode)
        0: cmd_if.cmd_ready = 1'b1;
        1: begin
          cmd_if.cmd_ready = ((pcnt % 4) == 0) || ((pcnt % 4) == 3);
          pcnt++;
        end
        default: cmd_if.cmd_ready = 1'b0;
      endcase
    end
  end

  // Stream monitor: checks every accepted word, stall stability and packet counting against the model.
  always @(negedge aclk) begin
    logic [15:0] exp_w;
    int eff_a, eff_p;
    logic exp_pd;
    if (!aresetn) begin
      m_pos = 0; m_aux = 0; m_fc = 0; frames_since_start = 0;
      prev_stall = 1'b0; prev_run = 1'b0;
    end else begin
      if (running && !prev_run) begin
        m_pos = 0; m_aux = 0; m_fc = 0; frames_since_start = 0;
      end
      prev_run = running;
      if (prev_stall) begin
        checkOutput("hold_valid", cmd_if.cmd_valid, 1);
        checkOutput("hold_data", cmd_if.cmd_data, prev_data);
        checkOutput("hold_last", cmd_if.cmd_last, prev_last);
      end
      if (cmd_if.cmd_valid && !cmd_if.cmd_ready) stall_cnt++;
      if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
        exp_w = (m_pos < 32) ? conv(m_pos, dsp_settle) : aux_tb[m_aux];
        checkOutput($sformatf("word%0d", m_pos), cmd_if.cmd_data, exp_w);
        checkOutput("last", cmd_if.cmd_last, (m_pos == 34));
        checkOutput("frame_start", frame_start, (m_pos == 0));
        if (m_pos == 0) frame_log.delete();
        frame_log.push_back(cmd_if.cmd_data);
        if (m_pos >= 32) begin
          aux_log.push_back(cmd_if.cmd_data);
          eff_a = (aux_len == 0) ? 1 : int'(aux_len);
          m_aux = (m_aux >= eff_a - 1) ? 0 : m_aux + 1;
        end
        words_acc++;
        if (m_pos == 34) begin
          checkOutput("frame_cnt", frame_cnt, m_fc);
          eff_p = (pkt_len == 0) ? 1 : int'(pkt_len);
          if (m_fc + 1 >= eff_p) begin exp_pd = 1'b1; m_fc = 0; end
          else begin exp_pd = 1'b0; m_fc++; end
          checkOutput("packet_done", packet_done, exp_pd);
          if (packet_done) pd_log.push_back(frames_since_start + 1);
          frames_done++;
          frames_since_start++;
          m_pos = 0;
        end else begin
          checkOutput("packet_done_mid", packet_done, 0);
          m_pos++;
        end
      end
      prev_stall = cmd_if.cmd_valid && !cmd_if.cmd_ready;
      prev_data  = cmd_if.cmd_data;
      prev_last  = cmd_if.cmd_last;
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "[TB] watchdog");
  end

  // Directed test sequence.
  initial begin
    int t_run, t_val, tgt, n;
    aresetn = 1'b1; run_en = 1'b0; dsp_settle = 1'b0; pkt_len = 16'd100; aux_len = 8'd3;
    aux_wr_en = 1'b0; aux_wr_addr = '0; aux_wr_data = '0;
    for (int i = 0; i < 8; i++) aux_tb[i] = 16'hE800 + 16'(i * 256);
    #1 aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    $display("[TB] reset state");
    checkOutput("rst_valid", cmd_if.cmd_valid, 0);
    checkOutput("rst_data", cmd_if.cmd_data, 0);
    checkOutput("rst_last", cmd_if.cmd_last, 0);
    checkOutput("rst_frame_start", frame_start, 0);
    checkOutput("rst_packet_done", packet_done, 0);
    checkOutput("rst_running", running, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_frame_cnt", frame_cnt, 0);
    #2 aresetn = 1'b1;
    for (int i = 0; i < 8; i++) writeAux(i, aux_tb[i]);

    $display("[TB] basic frame");
    applyStimulus(1'b1, 0, 1'b0);
    waitRunning(1'b1, 10);
    t_run = cyc;
    waitValid(150);
    t_val = cyc;
    checkOutput("first_valid_latency", t_val - t_run, 100);
    waitFrames(1, 200);
    checkOutput("b_len", frame_log.size(), 35);
    checkOutput("b_w0", frame_log[0], 16'h0000);
    checkOutput("b_w1", frame_log[1], 16'h0100);
    checkOutput("b_w31", frame_log[31], 16'h1F00);
    checkOutput("b_w32", frame_log[32], 16'hE800);
    checkOutput("b_w33", frame_log[33], 16'hE900);
    checkOutput("b_w34", frame_log[34], 16'hEA00);

    $display("[TB] backpressure with dsp_settle");
    applyStimulus(1'b1, 1, 1'b1);
    waitFrames(2, 300);
    checkOutput("bp_len", frame_log.size(), 35);
    checkOutput("bp_w0", frame_log[0], 16'h0001);
    checkOutput("bp_w5", frame_log[5], 16'h0501);
    checkOutput("bp_w31", frame_log[31], 16'h1F01);
    checkOutput("bp_w32", frame_log[32], 16'hE800);
    checkOutput("bp_w34", frame_log[34], 16'hEA00);
    checkOutput("bp_stalls_seen", (stall_cnt > 0), 1);

    $display("[TB] aux wrap");
    applyStimulus(1'b0, 0, 1'b0);
    waitRunning(1'b0, 10);
    aux_len = 8'd5;
    aux_log.delete();
    applyStimulus(1'b1, 0, 1'b0);
    tgt = frames_done + 4;
    waitFrames(tgt, 600);
    checkOutput("wrap_n", aux_log.size(), 12);
    for (int i = 0; i < 12; i++)
      checkOutput($sformatf("wrap_%0d", i), aux_log[i], 16'hE800 + 16'((i % 5) * 256));

    $display("[TB] packets");
    applyStimulus(1'b0, 0, 1'b0);
    waitRunning(1'b0, 10);
    aux_len = 8'd3;
    pkt_len = 16'd8;
    pd_log.delete();
    applyStimulus(1'b1, 0, 1'b0);
    tgt = frames_done + 20;
    waitFrames(tgt, 2400);
    @(negedge aclk); @(negedge aclk);
    checkOutput("pkt_count", pd_log.size(), 2);
    checkOutput("pkt_first", pd_log[0], 8);
    checkOutput("pkt_second", pd_log[1], 16);
    checkOutput("pkt_frame_cnt", frame_cnt, 4);
    pkt_len = 16'd0;
    tgt = frames_done + 3;
    waitFrames(tgt, 400);
    @(negedge aclk); @(negedge aclk);
    checkOutput("pkt0_count", pd_log.size(), 5);
    checkOutput("pkt0_frame_cnt", frame_cnt, 0);

    $display("[TB] frame-aligned stop");
    waitPos(10, 200);
    applyStimulus(1'b0, 0, 1'b0);
    tgt = frames_done + 1;
    waitFrames(tgt, 100);
    checkOutput("stop_len", frame_log.size(), 35);
    @(negedge aclk); @(negedge aclk);
    checkOutput("stop_running", running, 0);
    n = words_acc;
    repeat (250) @(negedge aclk);
    checkOutput("stop_quiet", words_acc, n);
    checkOutput("stop_no_overrun", overrun, 0);

    $display("[TB] overrun");
    applyStimulus(1'b1, 2, 1'b0);
    waitValid(150);
    repeat (110) @(negedge aclk);
    checkOutput("ovr_set", overrun, 1);
    applyStimulus(1'b1, 0, 1'b0);
    tgt = frames_done + 1;
    waitFrames(tgt, 100);
    applyStimulus(1'b0, 0, 1'b0);
    waitRunning(1'b0, 10);
    repeat (5) @(negedge aclk);
    checkOutput("ovr_sticky", overrun, 1);

    $display("[TB] async reset mid-frame");
    applyStimulus(1'b1, 0, 1'b0);
    waitRunning(1'b1, 10);
    checkOutput("ovr_cleared", overrun, 0);
    waitPos(20, 200);
    #2 aresetn = 1'b0;
    #1;
    checkOutput("arst_valid", cmd_if.cmd_valid, 0);
    checkOutput("arst_data", cmd_if.cmd_data, 0);
    checkOutput("arst_last", cmd_if.cmd_last, 0);
    checkOutput("arst_running", running, 0);
    checkOutput("arst_frame_start", frame_start, 0);
    @(negedge aclk);
    #2 aresetn = 1'b1;
    tgt = frames_done + 1;
    waitFrames(tgt, 300);
    checkOutput("arst_restart_len", frame_log.size(), 35);
    checkOutput("arst_restart_w0", frame_log[0], 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
